// File: rtl/btn_pkg.sv
// btn_pkg: shared state encodings and 100 MHz board defaults for the button debouncer
package btn_pkg;
  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;
  localparam logic [19:0] DEF_STABLE_CYCLES = 20'd500000;
  localparam logic [27:0] DEF_HOLD_CYCLES   = 28'd100000000;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous bit
module bit_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk)
    ff <= rst ? {SYNC_STAGES{RESET_VAL}} : {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/btn_debouncer.sv
// btn_debouncer: synchronize, stability-filter and edge-detect a push button
// Define BTN_DEBOUNCE_HOLD_EN to build the long-press hold flag.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter int          CNT_W         = 20,
  parameter logic [CNT_W-1:0] STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic        ACTIVE_LOW    = 1'b0,
  parameter logic [27:0] HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);
  localparam logic [CNT_W-1:0] LAST = STABLE_CYCLES - CNT_W'(1);
  logic s, commit;
  logic [1:0] state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(ACTIVE_LOW ? ~btn_raw : btn_raw),
    .q(s)
  );
  always_comb begin
    state_n = state;
    cnt_n = '0;
    commit = 1'b0;
    case (state)
      RELEASED: if (s) begin
        commit = LAST == '0;
        state_n = WAIT_PRESS;
        cnt_n = CNT_W'(1);
      end
      WAIT_PRESS:
        if (!s) state_n = RELEASED;
        else if (cnt == LAST) commit = 1'b1;
        else cnt_n = cnt + 1'b1;
      PRESSED: if (!s) begin
        commit = LAST == '0;
        state_n = WAIT_RELEASE;
        cnt_n = CNT_W'(1);
      end
      WAIT_RELEASE:
        if (s) state_n = PRESSED;
        else if (cnt == LAST) commit = 1'b1;
        else cnt_n = cnt + 1'b1;
    endcase
    if (commit) begin
      state_n = btn_level ? RELEASED : PRESSED;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      btn_level <= btn_level ^ commit;
      btn_press <= commit & ~btn_level;
      btn_release <= commit & btn_level;
    end
  end
`ifdef BTN_DEBOUNCE_HOLD_EN
  logic [27:0] hcnt;
  // counts while pressed (bounces in WAIT_RELEASE keep it), clears with the release strobe
  always_ff @(posedge clk) begin
    if (rst || (commit && btn_level)) hcnt <= '0;
    else if (btn_level && hcnt != HOLD_CYCLES) hcnt <= hcnt + 1'b1;
  end
  assign btn_hold = hcnt == HOLD_CYCLES;
`else
  assign btn_hold = 1'b0 & (|HOLD_CYCLES);
`endif
endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: table-driven, directed and random checks against a sample-window model
module tb_btn_debouncer;
  localparam int N = 8;
  localparam int SS = 2;
  localparam int H = 32;
  localparam bit HE =
`ifdef BTN_DEBOUNCE_HOLD_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {
    bit rst;
    bit raw;
    int cyc;
    bit lvl;
    int np;
    int nr;
    bit hold;
  } seg_t;
  logic clk, rst, raw;
  logic lvl, prs, rel, hld, lvl_a, prs_a, rel_a, hld_a;
  int ncmp = 0, nfail = 0, tot_p = 0, tot_r = 0;
  bit sq[$];
  bit sh[$];
  bit m_level, m_press, m_rel;
  int m_hcnt;
  btn_debouncer #(.SYNC_STAGES(SS), .CNT_W(20), .STABLE_CYCLES(20'd8), .ACTIVE_LOW(1'b0),
                  .HOLD_CYCLES(28'd32)) dut (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_hold(hld));
  btn_debouncer #(.SYNC_STAGES(SS), .CNT_W(20), .STABLE_CYCLES(20'd8), .ACTIVE_LOW(1'b1),
                  .HOLD_CYCLES(28'd32)) dut_al (
    .clk(clk), .rst(rst), .btn_raw(~raw),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_hold(hld_a));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Model: s is raw delayed SS edges; level flips once the last N samples since the last flip all disagree with it.
  initial for (int i = 0; i < SS; i++) sq.push_back(1'b0);
  always @(posedge clk) begin
    if (rst) begin
      sq.delete();
      for (int i = 0; i < SS; i++) sq.push_back(1'b0);
      sh.delete();
      m_level = 0; m_press = 0; m_rel = 0; m_hcnt = 0;
    end else begin
      bit s, flip, was;
      s = sq.pop_front();
      sq.push_back(raw);
      sh.push_back(s);
      if (sh.size() > N) void'(sh.pop_front());
      flip = sh.size() == N;
      foreach (sh[i]) if (sh[i] == m_level) flip = 0;
      was = m_level;
      m_press = flip && !was;
      m_rel = flip && was;
      if (flip) begin
        m_level = !was;
        sh.delete();
      end
      m_hcnt = m_rel ? 0 : (was && m_hcnt < H) ? m_hcnt + 1 : m_hcnt;
    end
  end
  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    bit [3:0] e;
    e = {m_level, m_press, m_rel, HE && m_hcnt == H};
    tot_p += int'(prs === 1'b1);
    tot_r += int'(rel === 1'b1);
    check("cycle dut {lvl,prs,rel,hold}", int'({lvl, prs, rel, hld}), int'(e));
    check("cycle dut_al {lvl,prs,rel,hold}", int'({lvl_a, prs_a, rel_a, hld_a}), int'(e));
  end
  task automatic run(input bit r, input bit v, input int cyc);
    rst = r;
    raw = v;
    repeat (cyc) @(posedge clk);
    #7;
  endtask
  // edges until the chosen output (0 press, 1 hold, 2 release) goes high; -1 if the bound expires
  task automatic wait_for(input int which, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk);
      #7;
      if ((which == 0 && prs) || (which == 1 && hld) || (which == 2 && rel)) begin
        n = k;
        return;
      end
    end
  endtask
  initial begin
    seg_t tbl[$];
    int p0, r0, lat;
    rst = 1'b1;
    raw = 1'b0;
    tbl.push_back('{1, 0, 3, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 40, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 20, 0, 0, 1, 0});
    for (int i = 0; i < 10; i++) tbl.push_back('{0, i % 2 == 0, 3, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 20, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 20, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 7, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 20, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 8, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 20, 0, 1, 1, 0});
    tbl.push_back('{0, 1, 7, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 10, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 20, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 50, 1, 1, 0, HE});
    tbl.push_back('{0, 0, 20, 0, 0, 1, 0});
    foreach (tbl[i]) begin
      p0 = tot_p;
      r0 = tot_r;
      run(tbl[i].rst, tbl[i].raw, tbl[i].cyc);
      ncmp++;
      if (lvl !== tbl[i].lvl || hld !== tbl[i].hold || tot_p - p0 != tbl[i].np || tot_r - r0 != tbl[i].nr) begin
        nfail++;
        $display("FAIL seg%0d: level=%b press=%0d release=%0d hold=%b, want %b %0d %0d %b",
                 i, lvl, tot_p - p0, tot_r - r0, hld, tbl[i].lvl, tbl[i].np, tbl[i].nr, tbl[i].hold);
      end
    end
    raw = 1'b1;
    wait_for(0, 30, lat);
    check("press latency", lat, 10);
    check("level with press", int'(lvl), 1);
    wait_for(1, 60, lat);
    check("hold after press", lat, HE ? H : -1);
    run(0, 0, 4);
    run(0, 1, 12);
    check("hold kept over release bounce", int'({lvl, hld}), int'({1'b1, HE}));
    raw = 1'b0;
    wait_for(2, 30, lat);
    check("release latency", lat, 10);
    check("hold clears with release", int'({lvl, hld}), 0);
    for (int i = 0; i < 150; i++)
      run($urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0 ? $urandom_range(20, 60) : $urandom_range(1, 12));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
